// File: rtl/rand_matrix_fill_if.sv
// rtl/rand_matrix_fill_if.sv - request, random-source and element-stream signals of rand_matrix_fill
interface rand_matrix_fill_if #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 3
);
  logic              start;
  logic [DIM_W-1:0]  rows;
  logic [DIM_W-1:0]  cols;
  logic [DATA_W-1:0] val_min;
  logic [DATA_W-1:0] val_max;
  logic              rnd_en;
  logic [DATA_W-1:0] rnd_in;
  logic              elem_valid;
  logic              elem_ready;
  logic [DATA_W-1:0] elem_data;
  logic [DIM_W-1:0]  elem_row;
  logic [DIM_W-1:0]  elem_col;
  logic              elem_last;
  logic              busy;
  logic              done;
  logic              err;

  // Requester, random generator and matrix sink side
  modport master (
    output start, rows, cols, val_min, val_max, rnd_in, elem_ready,
    input  rnd_en, elem_valid, elem_data, elem_row, elem_col, elem_last, busy, done, err
  );

  // Fill engine side
  modport slave (
    input  start, rows, cols, val_min, val_max, rnd_in, elem_ready,
    output rnd_en, elem_valid, elem_data, elem_row, elem_col, elem_last, busy, done, err
  );
endinterface

// File: rtl/rand_matrix_fill.sv
// rtl/rand_matrix_fill.sv - random matrix filler mapping generator bytes into [val_min, val_max]; optional RAND_FILL_REJECT_EN
module rand_matrix_fill #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  rand_matrix_fill_if.slave bus
);
  localparam int RNG_W = DATA_W + 1;
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_SAMPLE, S_REDUCE, S_OUTPUT, S_FINISH
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  rows_q, cols_q, row_q, col_q;
  logic [DATA_W-1:0] min_q, max_q;
  logic [RNG_W-1:0]  range_q, acc_q;

  logic              rnd_en_q, elem_valid_q, elem_last_q, busy_q, done_q, err_q;
  logic [DATA_W-1:0] elem_data_q;
  logic [DIM_W-1:0]  elem_row_q, elem_col_q;

`ifdef RAND_FILL_REJECT_EN
  localparam int LIM_W = DATA_W + 2;
  localparam logic [LIM_W-1:0] FULL = LIM_W'(1) << DATA_W;
  // limit_q: largest multiple of range not above 2^DATA_W; bytes at or above it are redrawn
  logic [LIM_W-1:0]  limit_q;
  logic              range_ok_q;
`endif

  logic             req_illegal;
  logic [RNG_W-1:0] range_calc;
  logic             at_last;

  assign req_illegal = (rows_q == '0) || (cols_q == '0) || (rows_q > MAX_D) ||
                       (cols_q > MAX_D) || (min_q > max_q);
  assign range_calc  = {1'b0, max_q} - {1'b0, min_q} + RNG_W'(1);
  assign at_last     = (row_q == rows_q - DIM_W'(1)) && (col_q == cols_q - DIM_W'(1));

  assign bus.rnd_en     = rnd_en_q;
  assign bus.elem_valid = elem_valid_q;
  assign bus.elem_data  = elem_data_q;
  assign bus.elem_row   = elem_row_q;
  assign bus.elem_col   = elem_col_q;
  assign bus.elem_last  = elem_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  // Sequencer: validate request, one generator advance per element, reduce modulo range, stream out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      range_q      <= '0;
      acc_q        <= '0;
      rnd_en_q     <= 1'b0;
      elem_valid_q <= 1'b0;
      elem_last_q  <= 1'b0;
      elem_data_q  <= '0;
      elem_row_q   <= '0;
      elem_col_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef RAND_FILL_REJECT_EN
      limit_q      <= '0;
      range_ok_q   <= 1'b0;
`endif
    end else begin
      rnd_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rows_q <= bus.rows;
            cols_q <= bus.cols;
            min_q  <= bus.val_min;
            max_q  <= bus.val_max;
            row_q  <= '0;
            col_q  <= '0;
            busy_q <= 1'b1;
`ifdef RAND_FILL_REJECT_EN
            limit_q    <= '0;
            range_ok_q <= 1'b0;
`endif
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
`ifdef RAND_FILL_REJECT_EN
          if (!range_ok_q) begin
            if (req_illegal) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
              state  <= S_FINISH;
            end else begin
              range_q    <= range_calc;
              range_ok_q <= 1'b1;
            end
          end else if (limit_q + {1'b0, range_q} <= FULL) begin
            limit_q <= limit_q + {1'b0, range_q};
          end else begin
            rnd_en_q <= 1'b1;
            state    <= S_FETCH;
          end
`else
          if (req_illegal) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= S_FINISH;
          end else begin
            range_q  <= range_calc;
            rnd_en_q <= 1'b1;
            state    <= S_FETCH;
          end
`endif
        end
        S_FETCH: begin
          state <= S_SAMPLE;
        end
        S_SAMPLE: begin
`ifdef RAND_FILL_REJECT_EN
          if ({2'b00, bus.rnd_in} >= limit_q) begin
            rnd_en_q <= 1'b1;
            state    <= S_FETCH;
          end else begin
            acc_q <= {1'b0, bus.rnd_in};
            state <= S_REDUCE;
          end
`else
          acc_q <= {1'b0, bus.rnd_in};
          state <= S_REDUCE;
`endif
        end
        S_REDUCE: begin
          if (acc_q >= range_q) begin
            acc_q <= acc_q - range_q;
          end else begin
            elem_data_q  <= acc_q[DATA_W-1:0] + min_q;
            elem_row_q   <= row_q;
            elem_col_q   <= col_q;
            elem_last_q  <= at_last;
            elem_valid_q <= 1'b1;
            state        <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (bus.elem_ready) begin
            elem_valid_q <= 1'b0;
            if (elem_last_q) begin
              done_q <= 1'b1;
              state  <= S_FINISH;
            end else begin
              if (col_q == cols_q - DIM_W'(1)) begin
                col_q <= '0;
                row_q <= row_q + DIM_W'(1);
              end else begin
                col_q <= col_q + DIM_W'(1);
              end
              rnd_en_q <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_FINISH: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rand_matrix_fill.sv
// tb/tb_rand_matrix_fill.sv - directed table-driven bench for rand_matrix_fill
module tb_rand_matrix_fill;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rand_matrix_fill_if #(.DATA_W(8), .DIM_W(3)) bus ();

  rand_matrix_fill #(.DATA_W(8), .MAX_DIM(5), .DIM_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Generator model: advances once per clock edge with rnd_en, shows seq_mem[n-1] after n advances
  logic [7:0] seq_mem [0:15];
  int gen_cnt = 0;
  int gen_base = 0;
  int gen_off;
  always @(posedge clk) if (bus.rnd_en) gen_cnt <= gen_cnt + 1;
  assign gen_off = gen_cnt - gen_base;
  assign bus.rnd_in = (gen_off >= 1 && gen_off <= 16) ? seq_mem[gen_off-1] : 8'hEE;

  // seq/expd hold bytes low-first: byte k is seq[8k+:8]
  typedef struct packed {
    logic [2:0]  rows;
    logic [2:0]  cols;
    logic [7:0]  vmin;
    logic [7:0]  vmax;
    logic [63:0] seq;
    logic [63:0] expd;
    logic [3:0]  nel;
    logic [3:0]  pulses;
    logic        er;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r, input int c, input int mn, input int mx,
                              input logic [63:0] s, input logic [63:0] e,
                              input int nel, input int pulses, input int er);
    vec_t v;
    v.rows = 3'(r); v.cols = 3'(c); v.vmin = 8'(mn); v.vmax = 8'(mx);
    v.seq = s; v.expd = e; v.nel = 4'(nel); v.pulses = 4'(pulses); v.er = 1'(er);
    return v;
  endfunction

  task automatic do_start(input logic [2:0] r, input logic [2:0] c, input logic [7:0] mn, input logic [7:0] mx);
    @(negedge clk);
    bus.rows = r; bus.cols = c; bus.val_min = mn; bus.val_max = mx; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic load_seq(input logic [63:0] s);
    for (int k = 0; k < 16; k++) seq_mem[k] = (k < 8) ? s[8*k +: 8] : 8'hEE;
    gen_base = gen_cnt;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int nseen = 0;
    int last_cyc = -10;
    int exp_cols;
    bit fin = 0;
    load_seq(v.seq);
    bus.elem_ready = 1'b1;
    do_start(v.rows, v.cols, v.vmin, v.vmax);
    exp_cols = (v.cols == 0) ? 1 : int'(v.cols);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (nseen > 0 && cyc == last_cyc + 1)
        chk({tag, " valid_drop"}, 64'(bus.elem_valid), 64'd0);
      if (bus.done) begin
        fin = 1;
        chk({tag, " err"}, 64'(bus.err), 64'(v.er));
        if (v.er) chk({tag, " err_latency"}, 64'(cyc), 64'd1);
        else      chk({tag, " done_latency"}, 64'(cyc), 64'(last_cyc + 1));
      end else if (bus.elem_valid) begin
        if (nseen >= int'(v.nel)) begin
          chk({tag, " extra_elem"}, 64'(nseen + 1), 64'(v.nel));
        end else begin
          chk({tag, " data"}, 64'(bus.elem_data), 64'(v.expd[8*nseen +: 8]));
          chk({tag, " row"},  64'(bus.elem_row),  64'(nseen / exp_cols));
          chk({tag, " col"},  64'(bus.elem_col),  64'(nseen % exp_cols));
          chk({tag, " last"}, 64'(bus.elem_last), 64'(nseen == int'(v.nel) - 1));
        end
        nseen++;
        last_cyc = cyc;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) chk({tag, " timeout_done"}, 64'd0, 64'd1);
    chk({tag, " elem_count"}, 64'(nseen), 64'(v.nel));
    chk({tag, " rnd_pulses"}, 64'(gen_cnt - gen_base), 64'(v.pulses));
    @(negedge clk);
    chk({tag, " idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.elem_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.elem_valid) chk({tag, " timeout_valid"}, 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] out_vec();
    return {36'd0, bus.rnd_en, bus.elem_valid, bus.elem_data, bus.elem_row, bus.elem_col,
            bus.elem_last, bus.busy, bus.done, bus.err, 8'd0};
  endfunction

  vec_t tbl [0:9];

  initial begin
    logic [63:0] snap;
    int p;
    logic [63:0] stall_exp;

    tbl[0] = mk(2, 3, 0, 9,
`ifdef RAND_FILL_REJECT_EN
                {8'd3, 8'd255, 8'd10, 8'd9, 8'd200, 8'd7, 8'd25},
                {8'd3, 8'd0, 8'd9, 8'd0, 8'd7, 8'd5}, 6, 7, 0);
`else
                {8'd255, 8'd10, 8'd9, 8'd200, 8'd7, 8'd25},
                {8'd5, 8'd0, 8'd9, 8'd0, 8'd7, 8'd5}, 6, 6, 0);
`endif
    tbl[1] = mk(1, 1, 0, 255, 64'hAB, 64'hAB, 1, 1, 0);
    tbl[2] = mk(0, 3, 0, 9, 64'd0, 64'd0, 0, 0, 1);
    tbl[3] = mk(6, 2, 0, 9, 64'd0, 64'd0, 0, 0, 1);
    tbl[4] = mk(2, 2, 9, 3, 64'd0, 64'd0, 0, 0, 1);
    tbl[5] = mk(3, 0, 0, 9, 64'd0, 64'd0, 0, 0, 1);
    tbl[6] = mk(1, 2, 10, 12, {8'd2, 8'd100}, {8'd12, 8'd11}, 2, 2, 0);
    tbl[7] = mk(1, 5, 7, 7, {8'd77, 8'd1, 8'd128, 8'd0, 8'd255},
                {8'd7, 8'd7, 8'd7, 8'd7, 8'd7}, 5, 5, 0);
`ifdef RAND_FILL_REJECT_EN
    tbl[8] = mk(1, 1, 0, 9, {8'd13, 8'd255}, 64'd3, 1, 2, 0);
`else
    tbl[8] = mk(1, 1, 0, 9, {8'd13, 8'd255}, 64'd5, 1, 1, 0);
`endif
    tbl[9] = mk(5, 1, 250, 255, {8'd251, 8'd100, 8'd7, 8'd6, 8'd0},
                {8'd255, 8'd254, 8'd251, 8'd250, 8'd250}, 5, 5, 0);

    bus.start = 1'b0; bus.rows = '0; bus.cols = '0; bus.val_min = '0; bus.val_max = '0;
    bus.elem_ready = 1'b0;
    load_seq(64'd0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-pressure: each element held 10 cycles with ready low
    stall_exp = {8'd99, 8'd99, 8'd42, 8'd50};
    load_seq({8'd199, 8'd99, 8'd42, 8'd150});
    bus.elem_ready = 1'b0;
    do_start(3'd2, 3'd2, 8'd0, 8'd99);
    for (int e = 0; e < 4; e++) begin
      wait_valid("stall");
      chk("stall data", 64'(bus.elem_data), 64'(stall_exp[8*e +: 8]));
      chk("stall row",  64'(bus.elem_row), 64'(e / 2));
      chk("stall col",  64'(bus.elem_col), 64'(e % 2));
      chk("stall last", 64'(bus.elem_last), 64'(e == 3));
      snap = out_vec();
      p = gen_cnt - gen_base;
      chk("stall pulses", 64'(p), 64'(e + 1));
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk("stall hold", out_vec(), snap);
        chk("stall no_advance", 64'(gen_cnt - gen_base), 64'(p));
      end
      bus.elem_ready = 1'b1;
      @(negedge clk);
      bus.elem_ready = 1'b0;
      chk("stall valid_drop", 64'(bus.elem_valid), 64'd0);
    end
    chk("stall done", 64'(bus.done), 64'd1);
    chk("stall total_pulses", 64'(gen_cnt - gen_base), 64'd4);
    @(negedge clk);

    // Reset while the third element of a 3x3 fill is pending
    load_seq({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2});
    bus.elem_ready = 1'b0;
    do_start(3'd3, 3'd3, 8'd0, 8'd255);
    for (int e = 0; e < 2; e++) begin
      wait_valid("rst");
      bus.elem_ready = 1'b1;
      @(negedge clk);
      bus.elem_ready = 1'b0;
    end
    wait_valid("rst");
    chk("rst third_data", 64'(bus.elem_data), 64'd4);
    #2 rst_n = 1'b0;
    #1 chk("rst async_clear", out_vec(), 64'd0);
    chk("rst pulses", 64'(gen_cnt - gen_base), 64'd3);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(1, 1, 0, 255, 64'h5A, 64'h5A, 1, 1, 0), "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rand_matrix_fill.md
Name: rand_matrix_fill

Overview:
- Consumer end of the 8-bit pseudo-random stream. It pulls one byte per element from an `en`/`dout` style generator and maps it into [val_min, val_max].
- It emits a rows×cols matrix in row-major order over a valid/ready element stream.
- It sits between the random source and matrix storage, and serves the calculator's "random matrix" input mode.

Parameters:
- DATA_W, 8, element width (unsigned); must equal random byte width.
- MAX_DIM, 5, largest legal row/column count.
- DIM_W, 3, width of rows/cols/index ports; must hold MAX_DIM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- rows  in  DIM_W  row count, latched on accepted start.
- cols  in  DIM_W  column count, latched on accepted start.
- val_min  in  DATA_W  inclusive lower bound, latched on start.
- val_max  in  DATA_W  inclusive upper bound, latched on start.
- rnd_en  out  1  one-cycle advance pulse to the random generator.
- rnd_in  in  DATA_W  generator output.
- elem_valid  out  1  element present.
- elem_ready  in  1  sink accepts element.
- elem_data  out  DATA_W  element value.
- elem_row  out  DIM_W  row index of element.
- elem_col  out  DIM_W  column index of element.
- elem_last  out  1  high with final element.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion, including the error case.
- err  out  1  one-cycle pulse with done when the request is illegal.

Behaviour:
- Reset: state IDLE; all outputs 0; internal registers cleared. Reset mid-operation aborts immediately, emits no done, and leaves the generator untouched.
- States: IDLE, CHECK, FETCH, SAMPLE, REDUCE, OUTPUT, FINISH.
- IDLE:
  - start=1 → latch rows, cols, val_min, val_max; row=col=0; go to CHECK.
  - start while busy is ignored.
- CHECK (1 cycle):
  - Illegal if rows=0, cols=0, rows>MAX_DIM, cols>MAX_DIM, or val_min>val_max.
  - Illegal → FINISH with err.
  - Legal → range = val_max - val_min + 1, 9-bit, 1..256; go to FETCH.
- FETCH: rnd_en=1 for exactly 1 cycle → SAMPLE.
- SAMPLE: acc <= rnd_in, i.e. the value after the advance; go to REDUCE.
- REDUCE:
  - While acc >= range: acc <= acc - range, one subtraction per cycle.
  - Otherwise elem_data <= acc + val_min, driving elem_row/elem_col and elem_last = (row==rows-1 && col==cols-1); go to OUTPUT.
  - range=256 needs zero subtractions.
  - Worst case range=1 takes 255 cycles.
- OUTPUT:
  - elem_valid=1. data, row, col and last stay stable until the handshake (elem_valid && elem_ready).
  - On handshake, if last → FINISH.
  - Otherwise col++, and col wraps to 0 with row++ at cols-1; go to FETCH.
  - elem_valid drops the cycle after handshake.
- FINISH: done=1 (err=1 if illegal) for 1 cycle → IDLE; busy drops the same edge.
- Generator advances exactly once per emitted element; there is no lookahead and no advance in the error path.
- Arithmetic: unsigned only. acc + val_min ≤ val_max always, so no overflow.

Optional Feature:
- Macro: RAND_FILL_REJECT_EN.
- Defined:
  - CHECK computes limit = largest multiple of range ≤ 256 by repeated addition (extra cycles allowed).
  - In SAMPLE, rnd_in >= limit is rejected and the block returns to FETCH.
  - Result: uniform distribution.
- Undefined: plain modulo as above, with slight bias for ranges not dividing 256.

Test Plan:
- rows=2, cols=3, min=0, max=9; bench rnd_in sequence 25,7,200,9,10,255 → elements 5,7,0,9,0,5 at (0,0)..(1,2); elem_last only on 6th; 6 rnd_en pulses; done one cycle after last handshake; err=0.
- min=0, max=255, 1×1, rnd_in 0xAB → elem_data 0xAB, zero REDUCE cycles, elem_last=1.
- rows=0 (and separately rows=6; min=9,max=3) → done=err=1 two cycles after start; no elem_valid; no rnd_en.
- 2×2, elem_ready held low 10 cycles on each element → data/row/col stable, single rnd_en per element, no element lost or duplicated.
- rst_n low during 3rd element of 3×3 → all outputs 0 asynchronously; new start afterwards begins at (0,0).
- RAND_FILL_REJECT_EN defined, min=0, max=9 (limit 250): rnd_in 255 then 13 → two rnd_en pulses, elem_data 3; undefined → single pulse, elem_data 5.
